// File: rtl/gsm_alarm_trigger.sv
// rtl/gsm_alarm_trigger.sv - manual/temperature trigger stage feeding key_flag pulses into the GSM SMS sender
// Optional build macro: TRIG_AUTO_REARM_EN (re-queue a temperature SMS at every cooldown expiry while the alarm persists)
module gsm_alarm_trigger #(
    parameter int                TEMP_W     = 12,
    parameter logic [TEMP_W-1:0] HIGH_TH    = TEMP_W'(600),
    parameter logic [TEMP_W-1:0] LOW_TH     = TEMP_W'(550),
    parameter int                CONFIRM_N  = 4,
    parameter int                DEB_CNT    = 1000000,
    parameter int                TICK_CNT   = 50000000,
    parameter int                COOLDOWN_S = 60,
    parameter int                BUSY_TO    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_in,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_data,
    input  logic              sms_busy,
    output logic              key_flag,
    output logic              alarm_active,
    output logic [1:0]        trig_src,
    output logic              busy_timeout
);

    localparam int DEB_W  = $clog2(DEB_CNT + 1);
    localparam int OVR_W  = $clog2(CONFIRM_N + 1);
    localparam int TICK_W = $clog2(TICK_CNT + 1);
    localparam int SEC_W  = $clog2(COOLDOWN_S + 1);
    localparam int TO_W   = $clog2(BUSY_TO + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [OVR_W-1:0]  OVR_LAST  = OVR_W'(CONFIRM_N - 1);
    localparam logic [OVR_W-1:0]  OVR_MAX   = OVR_W'(CONFIRM_N);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CNT - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(COOLDOWN_S - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TO - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FIRE      = 3'd1;
    localparam logic [2:0] WAIT_ACK  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] COOLDOWN  = 3'd4;

    logic              key_s1;
    logic              key_s2;
    logic              key_deb;
    logic [DEB_W-1:0]  deb_cnt;
    logic              man_req;

    logic [OVR_W-1:0]  over_cnt;
    logic              temp_req;
    logic              temp_low;

    logic [2:0]        state;
    logic              pend_man;
    logic              pend_temp;
    logic [TO_W-1:0]   to_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [SEC_W-1:0]  sec_cnt;
    logic              cool_done;
    logic              rearm;

    // A sample below LOW_TH clears the alarm and any temperature request still waiting.
    assign temp_low  = temp_valid && (temp_data < LOW_TH);

    // Last tick of the last cooldown second, not pre-empted by a manual request.
    assign cool_done = (state == COOLDOWN) && !pend_man &&
                       (tick_cnt == TICK_LAST) && (sec_cnt == SEC_LAST);

`ifdef TRIG_AUTO_REARM_EN
    assign rearm = cool_done && alarm_active && !temp_low;
`else
    assign rearm = 1'b0;
`endif

    assign key_flag = (state == FIRE);

    // Two-flop synchroniser; released level out of reset so no phantom press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    // Accept a new key level after DEB_CNT cycles of disagreement; a press edge raises man_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            key_deb <= 1'b1;
            man_req <= 1'b0;
        end else begin
            man_req <= 1'b0;
            if (key_s2 == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                key_deb <= key_s2;
                man_req <= ~key_s2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Confirmation counter with hysteresis; temp_req marks the alarm's rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            over_cnt     <= '0;
            alarm_active <= 1'b0;
            temp_req     <= 1'b0;
        end else begin
            temp_req <= 1'b0;
            if (temp_valid) begin
                if (temp_data >= HIGH_TH) begin
                    if (over_cnt != OVR_MAX) begin
                        over_cnt <= over_cnt + 1'b1;
                    end
                    if (over_cnt >= OVR_LAST) begin
                        alarm_active <= 1'b1;
                        temp_req     <= ~alarm_active;
                    end
                end else begin
                    over_cnt <= '0;
                    if (temp_low) begin
                        alarm_active <= 1'b0;
                    end
                end
            end
        end
    end

    // Pending requests: a new request wins over the clear so nothing is lost in the FIRE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_man  <= 1'b0;
            pend_temp <= 1'b0;
        end else begin
            if (man_req) begin
                pend_man <= 1'b1;
            end else if (state == FIRE) begin
                pend_man <= 1'b0;
            end
            if (temp_req || rearm) begin
                pend_temp <= 1'b1;
            end else if ((state == FIRE) || temp_low) begin
                pend_temp <= 1'b0;
            end
        end
    end

    // Fire/handshake/cooldown sequencer guarding the sender.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            trig_src     <= 2'b00;
            busy_timeout <= 1'b0;
            to_cnt       <= '0;
            tick_cnt     <= '0;
            sec_cnt      <= '0;
        end else begin
            busy_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if ((pend_man || pend_temp) && !sms_busy) begin
                        state    <= FIRE;
                        trig_src <= {pend_temp, pend_man};
                    end
                end
                FIRE: begin
                    state  <= WAIT_ACK;
                    to_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (sms_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        state        <= IDLE;
                        busy_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!sms_busy) begin
                        state    <= COOLDOWN;
                        tick_cnt <= '0;
                        sec_cnt  <= '0;
                    end
                end
                COOLDOWN: begin
                    if (pend_man) begin
                        state <= IDLE;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (sec_cnt == SEC_LAST) begin
                            state <= IDLE;
                        end else begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gsm_alarm_trigger.md
Name: gsm_alarm_trigger

Overview:
Upstream trigger stage for the GSM SMS sender. It watches a debounced manual alarm button and a temperature sample stream with confirmation and hysteresis, and issues one-cycle `key_flag` pulses into the sender. It handshakes against the sender's busy flag and enforces a cooldown, so the modem is never re-triggered mid-sequence or spammed.

Parameters:
- TEMP_W, 12, width of temperature sample (unsigned)
- HIGH_TH, 12'd600, alarm-set threshold (inclusive, temp_data >= HIGH_TH)
- LOW_TH, 12'd550, alarm-clear threshold (exclusive, temp_data < LOW_TH); LOW_TH < HIGH_TH required
- CONFIRM_N, 4, consecutive high samples needed to set alarm
- DEB_CNT, 1000000, cycles of stable raw key level to accept (20 ms @ 50 MHz)
- TICK_CNT, 50000000, cycles per cooldown tick (1 s @ 50 MHz)
- COOLDOWN_S, 60, cooldown length in ticks after each SMS
- BUSY_TO, 1024, cycles to wait for sms_busy to rise after a fire

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_in  in  1  raw push button, active-low, asynchronous
- temp_valid  in  1  one-cycle strobe, temp_data valid
- temp_data  in  TEMP_W  temperature sample
- sms_busy  in  1  sender busy (sender's en_choice)
- key_flag  out  1  one-cycle start pulse to sender
- alarm_active  out  1  confirmed over-temperature state
- trig_src  out  2  source of last fire: bit0 manual, bit1 temperature
- busy_timeout  out  1  one-cycle pulse, sender never acknowledged

Behaviour:
- Reset: clk/rst_n as decided, asynchronous active-low.
  - Outputs 0. FSM in IDLE. All counters 0. Pending flags 0.
  - Debounced key level resets to 1 (released), so no press is seen out of reset.
- Key path:
  - 2-FF synchroniser on key_in.
  - Debounce counter restarts on any change of the synced level versus the debounced level.
  - After DEB_CNT consecutive equal cycles, the debounced level is updated.
  - A 1→0 transition of the debounced level produces man_req for one cycle.
- Temperature path, evaluated only on temp_valid:
  - temp_data >= HIGH_TH: over_cnt increments, saturating at CONFIRM_N. Reaching CONFIRM_N sets alarm_active.
  - LOW_TH <= temp_data < HIGH_TH: over_cnt = 0; alarm_active holds.
  - temp_data < LOW_TH: over_cnt = 0; alarm_active = 0.
  - temp_req = one-cycle pulse on the 0→1 edge of alarm_active.
- Request latching:
  - man_req sets pend_man; temp_req sets pend_temp.
  - Both are cleared when consumed by FIRE.
  - pend_temp is also cleared if alarm_active drops before it is consumed.
- FSM:
  - IDLE: if (pend_man | pend_temp) and sms_busy == 0, go to FIRE. If sms_busy == 1, requests stay pending.
  - FIRE (1 cycle):
    - key_flag = 1.
    - trig_src = {pend_temp, pend_man}; simultaneous requests give 2'b11 and a single fire.
    - Clear both pending flags, then go to WAIT_ACK.
  - WAIT_ACK: sms_busy = 1 goes to WAIT_DONE. After BUSY_TO cycles without it, pulse busy_timeout and go to IDLE, with no cooldown.
  - WAIT_DONE: sms_busy = 0 goes to COOLDOWN; the tick and tick-counter are cleared.
  - COOLDOWN:
    - Count COOLDOWN_S ticks, then go to IDLE.
    - pend_man during COOLDOWN aborts the cooldown and goes to IDLE; manual always gets through.
    - pend_temp raised during COOLDOWN is held until cooldown ends.
- Latency: man_req or temp_req in IDLE with sms_busy = 0 gives key_flag 2 cycles later (latch, then FIRE).
- trig_src holds its value between fires. busy_timeout is otherwise 0.
- Reset mid-operation aborts any state immediately. key_flag never asserts during reset or in the cycle after deassertion.

Optional Feature:
- TRIG_AUTO_REARM_EN defined: at COOLDOWN expiry, if alarm_active = 1, set pend_temp, so a persistent alarm re-sends an SMS every cooldown period.
- TRIG_AUTO_REARM_EN undefined: one temperature SMS per alarm episode. alarm_active must clear (< LOW_TH) and re-confirm before the next temperature fire.

Test Plan:
Bench overrides: DEB_CNT=8, TICK_CNT=10, COOLDOWN_S=3, BUSY_TO=16, CONFIRM_N=4.
- Key bounce, 3-cycle lows, then held low 20 cycles with sms_busy=0 → exactly one key_flag, trig_src=2'b01; bounces alone give no pulse.
- Samples 610, 610, 610, 560, 610 ×4 → alarm_active rises only after the final 4th consecutive 610; one key_flag, trig_src=2'b10; a following 560 keeps alarm_active=1, a following 500 clears it.
- Fire, sms_busy held 0 → busy_timeout pulses 17 cycles after key_flag, FSM returns to IDLE; a new press fires again without cooldown.
- Fire, sms_busy high 50 cycles then low, alarm re-confirmed during cooldown → second key_flag only after 30 cycles of cooldown; a press mid-cooldown fires immediately.
- man_req and temp_req in the same cycle → single key_flag, trig_src=2'b11; with sms_busy=1 in IDLE, no fire until busy drops.
- TRIG_AUTO_REARM_EN on, temperature held at 610 → key_flag repeats after each cooldown; off → exactly one key_flag.
